// File: rtl/if_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface if_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [31:0]     rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/if_stage.sv
// rv32i fetch stage: owns the fetch PC, keeps at most one imem request in flight,
// and feeds the IF/ID register with a one-entry hold buffer for decode stalls.
module if_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  if_stage_if.master      imem,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            valid_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] inflight_pc;
  logic            hold_valid;
  logic [31:0]     hold_instr;
  logic [XLEN-1:0] hold_pc;

  logic kill;
  logic req_fire;
  logic rsp_take;

  assign kill           = flush_d | redirect_valid;
  assign imem.req_valid = (state == S_REQ) & ~hold_valid & ~redirect_valid;
  assign imem.req_addr  = pc_f;
  assign req_fire       = imem.req_valid & imem.req_ready;
  assign rsp_take       = (state == S_WAIT) & imem.rsp_valid & ~kill;

  // A killed fetch still owes us a response; S_DROP swallows it so the
  // one-outstanding invariant holds without imem needing a cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc_f        <= RESET_PC;
      inflight_pc <= '0;
    end else begin
      if (redirect_valid)
        pc_f <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)
        pc_f <= pc_f + PC_STEP;

      unique case (state)
        S_REQ: begin
          if (req_fire) begin
            inflight_pc <= pc_f;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.rsp_valid)
            state <= S_REQ;
          else if (kill)
            state <= S_DROP;
        end
        S_DROP: begin
          if (imem.rsp_valid)
            state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // IF/ID register and hold buffer; the hold buffer can never be full when a
  // response lands because no request issues while it is occupied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_d    <= 1'b0;
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= PC_STEP;
      hold_valid <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= '0;
    end else if (kill) begin
      valid_d    <= 1'b0;
      instr_d    <= NOP_INSTR;
      hold_valid <= 1'b0;
    end else if (stall_d) begin
      if (rsp_take) begin
        hold_valid <= 1'b1;
        hold_instr <= imem.rsp_data;
        hold_pc    <= inflight_pc;
      end
    end else if (hold_valid) begin
      valid_d    <= 1'b1;
      instr_d    <= hold_instr;
      pc_d       <= hold_pc;
      pc_plus4_d <= hold_pc + PC_STEP;
      hold_valid <= 1'b0;
    end else if (rsp_take) begin
      valid_d    <= 1'b1;
      instr_d    <= imem.rsp_data;
      pc_d       <= inflight_pc;
      pc_plus4_d <= inflight_pc + PC_STEP;
    end else begin
      valid_d <= 1'b0;
      instr_d <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, wrap-around instance, and a
// randomized run against a transaction-level fetch model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk;
  logic rst_n, rst_n2;
  logic stall, flush, redir;
  logic [31:0] rpc;
  logic stall2;
  logic vd, vd2;
  logic [31:0] instr, instr2, pcd, pcd2, pc4, pc4_2;

  int n_tests = 0;
  int n_fail  = 0;

  if_stage_if #(.XLEN(32)) imem1 ();
  if_stage_if #(.XLEN(32)) imem2 ();

  if_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem1.master),
    .stall_d(stall), .flush_d(flush), .redirect_valid(redir), .redirect_pc(rpc),
    .valid_d(vd), .instr_d(instr), .pc_d(pcd), .pc_plus4_d(pc4)
  );

  if_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .rst_n(rst_n2), .imem(imem2.master),
    .stall_d(stall2), .flush_d(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .valid_d(vd2), .instr_d(instr2), .pc_d(pcd2), .pc_plus4_d(pc4_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rdy, rv;
    logic [31:0] rdata;
    bit          stall, flush, redir;
    logic [31:0] rpc;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_vd;
    logic [31:0] e_instr, e_pcd, e_pc4;
  } vec_t;

  vec_t vecs[17];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Reference model: a fetch pointer, an optional outstanding request
  // (possibly already cancelled), an optional buffered instruction, and decode's view.
  logic [31:0] m_pc, m_out_addr, m_hold_instr, m_hold_pc, m_instr, m_pcd, m_pc4;
  bit          m_out_busy, m_out_alive, m_hold_busy, m_vd;

  initial begin
    bit          erv, got, kill, fire, pend, dut_fire;
    int unsigned cnt;
    logic [31:0] paddr, dut_addr;

    vecs[0]  = '{H, L, 32'h0,         L, L, L, 32'h0,   H, 32'h000, L, NOP,          32'h0, 32'h4};
    vecs[1]  = '{H, H, 32'h0050_0093, L, L, L, 32'h0,   L, 32'h004, L, NOP,          32'h0, 32'h4};
    vecs[2]  = '{H, L, 32'h0,         L, L, L, 32'h0,   H, 32'h004, H, 32'h0050_0093, 32'h0, 32'h4};
    vecs[3]  = '{L, H, 32'h00A0_0113, H, L, L, 32'h0,   L, 32'h008, L, NOP,          32'h0, 32'h4};
    vecs[4]  = '{H, L, 32'h0,         H, L, L, 32'h0,   L, 32'h008, L, NOP,          32'h0, 32'h4};
    vecs[5]  = '{H, L, 32'h0,         L, L, L, 32'h0,   L, 32'h008, L, NOP,          32'h0, 32'h4};
    vecs[6]  = '{H, L, 32'h0,         L, L, L, 32'h0,   H, 32'h008, H, 32'h00A0_0113, 32'h4, 32'h8};
    vecs[7]  = '{L, L, 32'h0,         L, L, H, 32'h103, L, 32'h00C, L, NOP,          32'h4, 32'h8};
    vecs[8]  = '{L, L, 32'h0,         L, L, L, 32'h0,   L, 32'h100, L, NOP,          32'h4, 32'h8};
    vecs[9]  = '{H, H, 32'hDEAD_BEEF, L, L, L, 32'h0,   L, 32'h100, L, NOP,          32'h4, 32'h8};
    vecs[10] = '{L, L, 32'h0,         L, L, L, 32'h0,   H, 32'h100, L, NOP,          32'h4, 32'h8};
    vecs[11] = '{H, L, 32'h0,         L, L, L, 32'h0,   H, 32'h100, L, NOP,          32'h4, 32'h8};
    vecs[12] = '{L, H, 32'h1234_5678, H, L, H, 32'h200, L, 32'h104, L, NOP,          32'h4, 32'h8};
    vecs[13] = '{L, L, 32'h0,         L, L, L, 32'h0,   H, 32'h200, L, NOP,          32'h4, 32'h8};
    vecs[14] = '{H, L, 32'h0,         L, L, L, 32'h0,   H, 32'h200, L, NOP,          32'h4, 32'h8};
    vecs[15] = '{L, L, 32'h0,         L, H, L, 32'h0,   L, 32'h204, L, NOP,          32'h4, 32'h8};
    vecs[16] = '{L, L, 32'h0,         L, L, L, 32'h0,   L, 32'h204, L, NOP,          32'h4, 32'h8};

    rst_n = 1'b0; rst_n2 = 1'b0;
    stall = 1'b0; flush = 1'b0; redir = 1'b0; rpc = '0; stall2 = 1'b0;
    imem1.req_ready = 1'b0; imem1.rsp_valid = 1'b0; imem1.rsp_data = '0;
    imem2.req_ready = 1'b0; imem2.rsp_valid = 1'b0; imem2.rsp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cycle table: fetch, stall-into-hold, redirect drop, redirect+rsp+stall, flush.
    for (int i = 0; i < 17; i++) begin
      imem1.req_ready = vecs[i].rdy;
      imem1.rsp_valid = vecs[i].rv;
      imem1.rsp_data  = vecs[i].rdata;
      stall = vecs[i].stall; flush = vecs[i].flush;
      redir = vecs[i].redir; rpc = vecs[i].rpc;
      #1;
      chk1 ($sformatf("vec%0d req_valid", i), imem1.req_valid, vecs[i].e_rv);
      chk32($sformatf("vec%0d req_addr", i),  imem1.req_addr,  vecs[i].e_addr);
      chk1 ($sformatf("vec%0d valid_d", i),   vd,              vecs[i].e_vd);
      chk32($sformatf("vec%0d instr_d", i),   instr,           vecs[i].e_instr);
      chk32($sformatf("vec%0d pc_d", i),      pcd,             vecs[i].e_pcd);
      chk32($sformatf("vec%0d pc_plus4_d", i), pc4,            vecs[i].e_pc4);
      @(negedge clk);
    end

    // Reset while a cancelled fetch is still outstanding.
    imem1.req_ready = 1'b0; imem1.rsp_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; redir = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1 ("drop_reset req_valid", imem1.req_valid, 1'b1);
    chk32("drop_reset req_addr",  imem1.req_addr,  32'h0);
    chk1 ("drop_reset valid_d",   vd,              1'b0);
    chk32("drop_reset instr_d",   instr,           NOP);

    // Fetch PC wrap from the top of the address space.
    @(negedge clk);
    rst_n2 = 1'b1;
    imem2.req_ready = 1'b1;
    #1;
    chk1 ("wrap req_valid0",  imem2.req_valid, 1'b1);
    chk32("wrap req_addr0",   imem2.req_addr,  32'hFFFF_FFFC);
    chk32("wrap pc4_reset",   pc4_2,           32'h4);
    @(negedge clk);
    imem2.rsp_valid = 1'b1; imem2.rsp_data = 32'h0010_0093;
    #1;
    chk1 ("wrap req_valid_wait", imem2.req_valid, 1'b0);
    chk32("wrap req_addr1",      imem2.req_addr,  32'h0);
    @(negedge clk);
    imem2.rsp_valid = 1'b0; imem2.req_ready = 1'b0;
    #1;
    chk1 ("wrap valid_d",    vd2,             1'b1);
    chk32("wrap instr_d",    instr2,          32'h0010_0093);
    chk32("wrap pc_d",       pcd2,            32'hFFFF_FFFC);
    chk32("wrap pc_plus4_d", pc4_2,           32'h0);
    chk1 ("wrap req_valid1", imem2.req_valid, 1'b1);
    chk32("wrap req_addr2",  imem2.req_addr,  32'h0);

    // Randomized run against the model.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 32'h0; m_out_busy = 0; m_out_alive = 0; m_out_addr = '0;
    m_hold_busy = 0; m_hold_instr = '0; m_hold_pc = '0;
    m_vd = 0; m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h4;
    pend = 0; cnt = 0; paddr = '0;

    for (int c = 0; c < 800; c++) begin
      imem1.req_ready = ($urandom_range(0, 9) < 7);
      stall = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 19) == 0);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = $urandom;
      imem1.rsp_valid = pend && (cnt == 0);
      imem1.rsp_data  = imem1.rsp_valid ? word_at(paddr) : $urandom;
      erv = !m_out_busy && !m_hold_busy && !redir;
      #1;
      chk1 ("rnd req_valid", imem1.req_valid, erv);
      chk32("rnd req_addr",  imem1.req_addr,  m_pc);
      chk1 ("rnd valid_d",   vd,              m_vd);
      chk32("rnd instr_d",   instr,           m_instr);
      chk32("rnd pc_d",      pcd,             m_pcd);
      chk32("rnd pc_plus4_d", pc4,            m_pc4);

      // Memory responder reacts to what the DUT actually issued.
      dut_fire = imem1.req_valid && imem1.req_ready;
      dut_addr = imem1.req_addr;
      if (imem1.rsp_valid) pend = 0;
      else if (pend) cnt--;
      if (dut_fire) begin
        pend = 1; paddr = dut_addr; cnt = $urandom_range(0, 2);
      end

      kill = flush || redir;
      fire = erv && imem1.req_ready;
      got  = 0;
      if (imem1.rsp_valid && m_out_busy) begin
        got = m_out_alive && !kill;
        m_out_busy = 0;
      end else if (m_out_busy && kill) begin
        m_out_alive = 0;
      end

      if (kill) begin
        m_vd = 0; m_instr = NOP; m_hold_busy = 0;
      end else if (stall) begin
        if (got) begin
          m_hold_busy = 1; m_hold_instr = word_at(m_out_addr); m_hold_pc = m_out_addr;
        end
      end else if (m_hold_busy) begin
        m_vd = 1; m_instr = m_hold_instr; m_pcd = m_hold_pc; m_pc4 = m_hold_pc + 32'd4;
        m_hold_busy = 0;
      end else if (got) begin
        m_vd = 1; m_instr = word_at(m_out_addr); m_pcd = m_out_addr; m_pc4 = m_out_addr + 32'd4;
      end else begin
        m_vd = 0; m_instr = NOP;
      end

      if (redir) begin
        m_pc = rpc & 32'hFFFF_FFFC;
      end else if (fire) begin
        m_out_busy = 1; m_out_alive = 1; m_out_addr = m_pc; m_pc = m_pc + 32'd4;
      end

      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
